// File: rtl/hash_table_checker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hash_table_checker_pkg                                               |
// | Shared hash width, state encodings and constants for the checker.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hash_table_checker_pkg;

    localparam int c_HASH_W = 128;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE  = 2'd0;
    localparam state_t c_STORE = 2'd1;
    localparam state_t c_SCAN  = 2'd2;

    localparam logic [c_HASH_W-1:0] c_NULL_HASH = '0;

endpackage
`default_nettype wire

// File: rtl/hash_table_checker_hash_entry_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hash_entry_ram                                                       |
// | DEPTH x HASH_W register array, synchronous write, async read.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hash_entry_ram #(
    parameter int DEPTH  = 8,
    parameter int HASH_W = 128,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [HASH_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [HASH_W-1:0] rdata
);

    // Contents deliberately have no reset; validity is tracked by the entry count.
    logic [HASH_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/hash_table_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hash_table_checker                                                   |
// | Stores target hashes and scans for a candidate hash, lowest index.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hash_table_checker
    import hash_table_checker_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int HASH_W = c_HASH_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_rdy,
    input  logic              check_rdy,
    input  logic [HASH_W-1:0] hash,
    output logic              result_rdy,
    output logic              match_found,
    output logic [IDX_W-1:0]  match_index,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              overflow
);

    localparam logic [IDX_W:0] c_DEPTH_CNT = (IDX_W + 1)'(DEPTH);

    state_t              r_state;
    logic                r_new_d;
    logic                r_check_d;
    logic [HASH_W-1:0]   r_hash;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W:0]      r_count;
    logic                r_result_rdy;
    logic                r_match_found;
    logic [IDX_W-1:0]    r_match_index;
    logic                r_overflow;

    logic                w_new_start;
    logic                w_check_start;
    logic                w_has_room;
    logic                w_we;
    logic                w_last;
    logic [HASH_W-1:0]   w_rdata;

    assign w_new_start   = new_rdy & ~r_new_d;
    assign w_check_start = check_rdy & ~r_check_d;
    assign w_has_room    = (r_count < c_DEPTH_CNT);
    // Gate the write with rst so a store interrupted by reset is lost.
    assign w_we          = (r_state == c_STORE) && w_has_room && !rst;
    assign w_last        = ({1'b0, r_idx} == (r_count - 1'b1));

    hash_entry_ram #(
        .DEPTH  (DEPTH),
        .HASH_W (HASH_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_count[IDX_W-1:0]),
        .wdata (r_hash),
        .raddr (r_idx),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_new_d       <= 1'b0;
            r_check_d     <= 1'b0;
            r_idx         <= '0;
            r_count       <= '0;
            r_result_rdy  <= 1'b1;
            r_match_found <= 1'b0;
            r_match_index <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_new_d   <= new_rdy;
            r_check_d <= check_rdy;
            case (r_state)
                c_IDLE: begin
                    // Store has priority; a coincident check edge is dropped.
                    if (w_new_start) begin
                        r_hash       <= hash;
                        r_result_rdy <= 1'b0;
                        r_state      <= c_STORE;
                    end else if (w_check_start) begin
                        r_hash        <= hash;
                        r_result_rdy  <= 1'b0;
                        r_match_found <= 1'b0;
                        r_idx         <= '0;
                        r_state       <= c_SCAN;
                    end
                end
                c_STORE: begin
                    if (w_has_room) begin
                        r_count <= r_count + 1'b1;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                    r_result_rdy <= 1'b1;
                    r_state      <= c_IDLE;
                end
                c_SCAN: begin
                    if (r_count == '0) begin
                        r_match_found <= 1'b0;
                        r_result_rdy  <= 1'b1;
                        r_state       <= c_IDLE;
                    end else if (w_rdata == r_hash) begin
                        r_match_found <= 1'b1;
                        r_match_index <= r_idx;
                        r_result_rdy  <= 1'b1;
                        r_state       <= c_IDLE;
                    end else if (w_last) begin
                        r_match_found <= 1'b0;
                        r_result_rdy  <= 1'b1;
                        r_state       <= c_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign result_rdy  = r_result_rdy;
    assign match_found = r_match_found;
    assign match_index = r_match_index;
    assign count       = r_count;
    assign full        = (r_count == c_DEPTH_CNT);
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_hash_table_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hash_table_checker                                                |
// | Directed and random checks against a queue-based table model.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hash_table_checker;

    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         new_rdy;
    logic         check_rdy;
    logic [127:0] hash;
    logic         result_rdy;
    logic         match_found;
    logic [2:0]   match_index;
    logic [3:0]   count;
    logic         full;
    logic         overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [127:0] model_q[$];
    bit           model_ovf;
    bit           model_mf;
    int           model_mi;

    localparam logic [127:0] H_PROBE = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] H_A     = 128'h31D6CFE0D16AE931B73C59D7E0C089C0;
    localparam logic [127:0] H_B     = 128'h8846F7EAEE8FB117AD06BDD830B7586C;
    localparam logic [127:0] H_C     = {128{1'b1}};

    hash_table_checker #(.DEPTH(DEPTH), .HASH_W(128)) dut (
        .clk         (clk),
        .rst         (rst),
        .new_rdy     (new_rdy),
        .check_rdy   (check_rdy),
        .hash        (hash),
        .result_rdy  (result_rdy),
        .match_found (match_found),
        .match_index (match_index),
        .count       (count),
        .full        (full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand_hash();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, 128'(count), 128'(model_q.size()));
        chk({tag, "_full"}, 128'(full), 128'(model_q.size() == DEPTH));
        chk({tag, "_ovf"}, 128'(overflow), 128'(model_ovf));
    endtask

    task automatic do_store(input logic [127:0] h);
        int n;
        if (model_q.size() < DEPTH) model_q.push_back(h);
        else model_ovf = 1'b1;
        hash = h;
        new_rdy = 1'b1;
        tick();
        chk("st_rdy_fall", 128'(result_rdy), 128'(0));
        n = 0;
        while (!result_rdy && n < 8) begin
            tick();
            n++;
        end
        new_rdy = 1'b0;
        chk("st_done", 128'(result_rdy), 128'(1));
        tick();
    endtask

    task automatic do_check(input string tag, input logic [127:0] h);
        bit found;
        int idx;
        int exp_lat;
        int lat;
        found = 1'b0;
        idx = 0;
        foreach (model_q[k]) begin
            if (!found && model_q[k] == h) begin
                found = 1'b1;
                idx = k;
            end
        end
        exp_lat = found ? idx + 1 : (model_q.size() == 0 ? 1 : model_q.size());
        hash = h;
        check_rdy = 1'b1;
        tick();
        chk({tag, "_rdy_fall"}, 128'(result_rdy), 128'(0));
        chk({tag, "_mf_clear"}, 128'(match_found), 128'(0));
        lat = 0;
        while (!result_rdy && lat < 100) begin
            tick();
            lat++;
        end
        check_rdy = 1'b0;
        model_mf = found;
        if (found) model_mi = idx;
        chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_found"}, 128'(match_found), 128'(model_mf));
        chk({tag, "_idx"}, 128'(match_index), 128'(model_mi));
        tick();
    endtask

    initial begin
        logic [127:0] r_h;
        logic [127:0] last7;
        logic [127:0] extra[2];
        int           lows;

        rst = 1'b1;
        new_rdy = 1'b0;
        check_rdy = 1'b0;
        hash = '0;
        model_ovf = 1'b0;
        model_mf = 1'b0;
        model_mi = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rdy", 128'(result_rdy), 128'(1));
        chk("rst_mf", 128'(match_found), 128'(0));
        chk("rst_mi", 128'(match_index), 128'(0));
        chk_status("rst");

        do_check("empty", H_PROBE);
        chk_status("empty");

        do_store(H_A);
        do_store(H_B);
        do_store(H_C);
        chk_status("abc");
        do_check("chk_b", H_B);
        do_check("chk_c", H_C);
        do_check("chk_d", rand_hash());

        // Fill to DEPTH, then two extra stores that must overflow.
        for (int i = 3; i < DEPTH; i++) begin
            r_h = rand_hash();
            if (i == DEPTH - 1) last7 = r_h;
            do_store(r_h);
        end
        extra[0] = rand_hash();
        extra[1] = rand_hash();
        do_store(extra[0]);
        do_store(extra[1]);
        chk_status("ovf");
        do_check("chk_x0", extra[0]);
        do_check("chk_x1", extra[1]);
        do_check("chk_last", last7);
        for (int i = 0; i < 4; i++) begin
            do_check("chk_rnd", model_q[$urandom_range(DEPTH - 1, 0)]);
        end

        // Reset in the middle of a scan of the full table.
        hash = rand_hash();
        check_rdy = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        check_rdy = 1'b0;
        tick();
        rst = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        model_mf = 1'b0;
        model_mi = 0;
        chk("mid_rdy", 128'(result_rdy), 128'(1));
        chk("mid_mf", 128'(match_found), 128'(0));
        chk("mid_mi", 128'(match_index), 128'(0));
        chk_status("mid");
        do_check("post_rst", H_A);

        // Duplicates resolve to the lowest index.
        do_store(H_A);
        do_store(H_B);
        do_store(H_A);
        do_check("dup_a", H_A);
        do_check("dup_b", H_B);

        // Coincident store and check edges, held 5 cycles: only one store.
        r_h = rand_hash();
        hash = r_h;
        new_rdy = 1'b1;
        check_rdy = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        new_rdy = 1'b0;
        check_rdy = 1'b0;
        tick();
        model_q.push_back(r_h);
        chk_status("simul");
        chk("simul_mf", 128'(match_found), 128'(model_mf));
        chk("simul_mi", 128'(match_index), 128'(model_mi));
        do_check("simul_new", r_h);

        // check_rdy level held 5 cycles must produce exactly one scan.
        hash = rand_hash();
        check_rdy = 1'b1;
        lows = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (!result_rdy) lows++;
            if (k == 4) check_rdy = 1'b0;
        end
        chk("held_busy", 128'(lows), 128'(model_q.size()));
        chk("held_mf", 128'(match_found), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
